// File: rtl/huff_pkg.sv
// huff_pkg: shared definitions for the Huffman build scheduler.
//   - HUFF_NSYM      : default number of symbol counters
//   - HUFF_SORT_TMO  : default last SORT_WAIT timer value before timeout
//   - state_e        : FSM state encodings (4 bits, exposed on the state port)
package huff_pkg;

    localparam int HUFF_NSYM     = 6;
    localparam int HUFF_SORT_TMO = 15;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_COUNT     = 4'd1,
        ST_CNTV      = 4'd2,
        ST_SORT_REQ  = 4'd3,
        ST_SORT_WAIT = 4'd4,
        ST_MERGE     = 4'd5,
        ST_SPLIT     = 4'd6,
        ST_CODEV     = 4'd7,
        ST_ERR       = 4'd8
    } state_e;

endpackage

// File: rtl/huff_tmo.sv
// huff_tmo: 4-bit saturating wait timer for the shared-sorter handshake.
//   clk     : clock
//   reset   : asynchronous active-high reset (clears the count)
//   clr     : synchronous clear, takes priority over en
//   en      : count up by one (saturates at 15, never wraps)
//   expired : count equals TMO
module huff_tmo #(
    parameter logic [3:0] TMO = 4'd15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (en && (cnt_q != 4'hF)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == TMO);

endmodule

// File: rtl/huff_sched.sv
// huff_sched: control FSM for a Huffman table build.
// Sequence: count symbols -> (sort, merge) x (NSYM-1) -> split x (NSYM-1)
// -> code table valid. A sorter that never answers ends in ERR.
//
// Handshake: sort_start is a one-cycle request to the shared sorter; the
// sorter answers with a one-cycle sort_done, which is only looked at while
// waiting in SORT_WAIT. A request not answered by the time the wait timer
// reaches SORT_TMO is a timeout.
//
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   gray_valid         : valid pixel this cycle (used in IDLE/COUNT only)
//   sort_done          : sorter completion pulse
//   cnt_en, CNT_valid  : counter enable, counts final
//   sort_start         : sorter request
//   merge_en, split_en : merge / code-assignment step strobes
//   code_valid, err    : table final, sorter timeout
//   busy, state, round : status / debug view of the FSM
module huff_sched
    import huff_pkg::*;
#(
    parameter int NSYM     = HUFF_NSYM,
    parameter int SORT_TMO = HUFF_SORT_TMO
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gray_valid,
    input  logic       sort_done,
    output logic       cnt_en,
    output logic       CNT_valid,
    output logic       sort_start,
    output logic       merge_en,
    output logic       split_en,
    output logic       code_valid,
    output logic       err,
    output logic       busy,
    output logic [3:0] state,
    output logic [2:0] round
);

    localparam logic [2:0] ROUND_MAX = 3'(NSYM - 2);

    state_e     state_q, state_d;
    logic [2:0] round_q, round_d;
    logic       tmo_expired;

    huff_tmo #(
        .TMO (4'(SORT_TMO))
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q == ST_SORT_REQ),
        .en      (state_q == ST_SORT_WAIT),
        .expired (tmo_expired)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            round_q <= 3'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE:  if (gray_valid) state_d = ST_COUNT;
            ST_COUNT: if (!gray_valid) state_d = ST_CNTV;
            ST_CNTV: begin
                state_d = ST_SORT_REQ;
                round_d = 3'd0;
            end
            ST_SORT_REQ: state_d = ST_SORT_WAIT;
            ST_SORT_WAIT: begin
                // A completion in the same cycle as the timeout still counts.
                if (sort_done) begin
                    state_d = ST_MERGE;
                end else if (tmo_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_MERGE: begin
                if (round_q == ROUND_MAX) begin
                    state_d = ST_SPLIT;
                end else begin
                    round_d = round_q + 3'd1;
                    state_d = ST_SORT_REQ;
                end
            end
            ST_SPLIT: begin
                if (round_q == 3'd0) begin
                    state_d = ST_CODEV;
                end else begin
                    round_d = round_q - 3'd1;
                end
            end
            ST_CODEV: state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        cnt_en     = 1'b0;
        CNT_valid  = 1'b0;
        sort_start = 1'b0;
        merge_en   = 1'b0;
        split_en   = 1'b0;
        code_valid = 1'b0;
        err        = 1'b0;
        case (state_q)
            ST_IDLE:     cnt_en     = gray_valid;
            ST_COUNT:    cnt_en     = gray_valid;
            ST_CNTV:     CNT_valid  = 1'b1;
            ST_SORT_REQ: sort_start = 1'b1;
            ST_MERGE:    merge_en   = 1'b1;
            ST_SPLIT:    split_en   = 1'b1;
            ST_CODEV:    code_valid = 1'b1;
            ST_ERR:      err        = 1'b1;
            default:     ;
        endcase
    end

    assign busy  = (state_q != ST_IDLE);
    assign state = state_q;
    assign round = round_q;

endmodule

// File: tb/tb_huff_sched.sv
module tb_huff_sched;
  import huff_pkg::*;

  localparam int NSYM = 6;
  localparam int TMO  = 15;
  localparam int W    = 15;  // {state, round, 7 strobes, busy}

  logic       clk = 1'b0;
  logic       reset;
  logic       gray_valid;
  logic       sort_done;
  logic       cnt_en, cnt_valid, sort_start, merge_en, split_en;
  logic       code_valid, err, busy;
  logic [3:0] state;
  logic [2:0] round;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  huff_sched #(.NSYM(NSYM), .SORT_TMO(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_valid (gray_valid),
    .sort_done  (sort_done),
    .cnt_en     (cnt_en),
    .CNT_valid  (cnt_valid),
    .sort_start (sort_start),
    .merge_en   (merge_en),
    .split_en   (split_en),
    .code_valid (code_valid),
    .err        (err),
    .busy       (busy),
    .state      (state),
    .round      (round)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         gv_q[$];
  logic         sd_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           rcur = 0;       // round value the model expects to be held
  int           split2_idx = -1;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got st=%0d rnd=%0d strb=%b busy=%b, want st=%0d rnd=%0d strb=%b busy=%b",
                  tag, got[14:11], got[10:8], got[7:1], got[0],
                  want[14:11], want[10:8], want[7:1], want[0]);
  endtask

  function automatic logic [W-1:0] observed();
    return {state, round, cnt_en, cnt_valid, sort_start, merge_en, split_en, code_valid, err, busy};
  endfunction

  // strb = {cnt_en, CNT_valid, sort_start, merge_en, split_en, code_valid, err}
  task automatic push(input state_e s, input int r, input logic gv, input logic sd, input logic [6:0] strb);
    exp_q.push_back({s, 3'(r), strb, (s != ST_IDLE)});
    gv_q.push_back(gv);
    sd_q.push_back(sd);
  endtask

  function automatic logic noise_bit(input bit noisy);
    return noisy && ($urandom_range(99, 0) < 40);
  endfunction

  // One complete build as a sequence of phases. d[r] is the cycle within
  // SORT_WAIT at which the sorter answers in round r; d[r] > TMO means never.
  task automatic build_run(input int len, input int d[NSYM-1], input bit noisy);
    int nidle;
    nidle = $urandom_range(3, 1);
    for (int i = 0; i < nidle; i++) push(ST_IDLE, rcur, 1'b0, noise_bit(noisy), 7'b0);
    push(ST_IDLE, rcur, 1'b1, noise_bit(noisy), 7'b1000000);
    for (int i = 1; i < len; i++) push(ST_COUNT, rcur, 1'b1, noise_bit(noisy), 7'b1000000);
    push(ST_COUNT, rcur, 1'b0, noise_bit(noisy), 7'b0);
    push(ST_CNTV, rcur, noise_bit(noisy), noise_bit(noisy), 7'b0100000);
    rcur = 0;
    for (int r = 0; r <= NSYM - 2; r++) begin
      push(ST_SORT_REQ, r, noise_bit(noisy), noise_bit(noisy), 7'b0010000);
      if (d[r] > TMO) begin
        for (int t = 0; t <= TMO; t++) push(ST_SORT_WAIT, r, noise_bit(noisy), 1'b0, 7'b0);
        push(ST_ERR, r, noise_bit(noisy), noise_bit(noisy), 7'b0000001);
        rcur = r;
        return;
      end
      for (int t = 0; t <= d[r]; t++) push(ST_SORT_WAIT, r, noise_bit(noisy), (t == d[r]), 7'b0);
      push(ST_MERGE, r, noise_bit(noisy), noise_bit(noisy), 7'b0001000);
    end
    for (int r = NSYM - 2; r >= 0; r--) begin
      if (r == 2) split2_idx = exp_q.size();
      push(ST_SPLIT, r, noise_bit(noisy), noise_bit(noisy), 7'b0000100);
    end
    push(ST_CODEV, 0, noise_bit(noisy), noise_bit(noisy), 7'b0000010);
    rcur = 0;
  endtask

  // ---------------- driver ----------------
  task automatic play(input int n);
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      @(negedge clk);
      gray_valid = gv_q.pop_front();
      sort_done  = sd_q.pop_front();
      #1;
      check_eq($sformatf("cyc%0d", cyc), observed(), exp_q.pop_front());
      cyc++;
    end
  endtask

  task automatic flush();
    exp_q.delete();
    gv_q.delete();
    sd_q.delete();
  endtask

  // ---------------- main ----------------
  initial begin
    int d[NSYM-1];
    int k;

    reset = 1'b1;
    gray_valid = 1'b0;
    sort_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset", observed(), {ST_IDLE, 3'd0, 7'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;

    // 10-cycle count, sorter answers immediately every round.
    for (int r = 0; r < NSYM - 1; r++) d[r] = 0;
    build_run(10, d, 1'b0);
    push(ST_IDLE, 0, 1'b0, 1'b0, 7'b0);
    play(exp_q.size());

    // Sorter never answers in one round.
    for (int r = 0; r < NSYM - 1; r++) d[r] = $urandom_range(14, 0);
    d[$urandom_range(NSYM - 2, 0)] = TMO + 1;
    build_run(4, d, 1'b1);
    play(exp_q.size());

    // Sorter answers exactly in the last tolerated cycle.
    for (int r = 0; r < NSYM - 1; r++) d[r] = $urandom_range(TMO, 0);
    d[2] = TMO;
    build_run(2, d, 1'b1);
    play(exp_q.size());

    // Randomized builds with pixel/sorter noise in the ignoring states.
    for (int n = 0; n < 16; n++) begin
      for (int r = 0; r < NSYM - 1; r++) d[r] = $urandom_range(TMO, 0);
      if ($urandom_range(99, 0) < 20) d[$urandom_range(NSYM - 2, 0)] = TMO + 1;
      build_run($urandom_range(12, 1), d, 1'b1);
      play(exp_q.size());
    end
    push(ST_IDLE, rcur, 1'b0, 1'b0, 7'b0);
    play(exp_q.size());

    // Reset in the middle of SPLIT at round 2.
    for (int r = 0; r < NSYM - 1; r++) d[r] = 0;
    split2_idx = -1;
    build_run(3, d, 1'b0);
    k = split2_idx + 1;
    play(k);
    gray_valid = 1'b0;
    sort_done = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("rst_async", observed(), {ST_IDLE, 3'd0, 7'b0, 1'b0});
    @(negedge clk);
    #1;
    check_eq("rst_hold", observed(), {ST_IDLE, 3'd0, 7'b0, 1'b0});
    reset = 1'b0;
    flush();
    @(negedge clk);
    sort_done = 1'b1;
    #1;
    check_eq("stray_sd", observed(), {ST_IDLE, 3'd0, 7'b0, 1'b0});
    @(negedge clk);
    sort_done = 1'b0;
    #1;
    check_eq("after_stray", observed(), {ST_IDLE, 3'd0, 7'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
